// File: rtl/scytale_pkg.sv
// scytale_pkg: shared types and constants for the scytale cipher engine.
//   state_e      : controller states LOAD / EMIT / DONE
//   MODE_*       : values of mode_i sampled with the start token
//   CNT_W        : counter width for the default buffer depth
package scytale_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_DECRYPT = 1'b0;
  localparam logic MODE_ENCRYPT = 1'b1;

  localparam int MAX_NOF_CHARS_DEF = 50;
  localparam int CNT_W             = $clog2(MAX_NOF_CHARS_DEF + 1);

endpackage

// File: rtl/scytale_buf.sv
// scytale_buf: character store for one message.
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address (combinational read)
//   rdata_o  out read data, 0 for addresses beyond the depth
// Storage is not reset; the controller tracks which entries are valid.
module scytale_buf
  import scytale_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = MAX_NOF_CHARS_DEF,
  parameter int AW      = CNT_W
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  logic [D_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (raddr_i < AW'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/scytale_codec.sv
// scytale_codec: buffers characters until START_TOKEN, then emits the N x M
// scytale transposition (decrypt or encrypt) one character per cycle.
//   clk, rst       clock, async active-high reset
//   data_i/valid_i input character stream
//   mode_i         0 = decrypt, 1 = encrypt (sampled with the token)
//   key_N/key_M    columns / rows (sampled with the token)
//   data_o/valid_o output character stream (data_o is 0 when idle)
//   busy           high while emitting
//   done_o         one-cycle pulse after the last character
//   err_o          sticky error: overflow or bad key; cleared by an accepted char
module scytale_codec
  import scytale_pkg::*;
#(
  parameter int                 D_WIDTH       = 8,
  parameter int                 KEY_WIDTH     = 8,
  parameter int                 MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA,
  parameter logic [D_WIDTH-1:0] PAD_CHAR      = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic                 mode_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int PW = 2 * KEY_WIDTH;

  state_e state_q, state_d;

  logic [CW-1:0] count_q;
  logic          err_q;
  // Inner counter runs 0..lim_q-1; each wrap advances outer_q, which runs
  // 0..olim_q-1. acc_q holds inner_q*olim_q, so the read address is
  // acc_q + outer_q without a runtime multiplier.
  logic [CW-1:0] lim_q, olim_q;
  logic [CW-1:0] inner_q, outer_q, acc_q;

  logic               tok, chr, keys_ok, full, we, inner_wrap, last;
  logic [PW-1:0]      prod;
  logic [CW-1:0]      addr;
  logic [D_WIDTH-1:0] rdata;

  assign tok  = valid_i && (data_i == START_TOKEN);
  assign chr  = valid_i && (data_i != START_TOKEN);
  assign full = (count_q == CW'(MAX_NOF_CHARS));

  // Only product in the design; evaluated once when the token arrives.
  assign prod    = PW'(key_N) * PW'(key_M);
  assign keys_ok = (key_N != '0) && (key_M != '0) && (prod <= PW'(MAX_NOF_CHARS));

  assign inner_wrap = (inner_q == lim_q - CW'(1));
  assign last       = inner_wrap && (outer_q == olim_q - CW'(1));
  assign addr       = acc_q + outer_q;
  assign we         = (state_q == LOAD) && chr && !full;

  scytale_buf #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (MAX_NOF_CHARS),
    .AW      (CW)
  ) u_buf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (count_q),
    .wdata_i (data_i),
    .raddr_i (addr),
    .rdata_o (rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (tok && keys_ok) state_d = EMIT;
      EMIT:    if (last)           state_d = DONE;
      DONE:                        state_d = LOAD;
      default:                     state_d = LOAD;
    endcase
  end

  // Output decode; driven purely from registers, so reset clears it at once.
  always_comb begin
    busy    = (state_q == EMIT);
    valid_o = busy;
    done_o  = (state_q == DONE);
    err_o   = err_q;
    data_o  = '0;
    if (busy) data_o = (addr < count_q) ? rdata : PAD_CHAR;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
      lim_q   <= '0;
      olim_q  <= '0;
      inner_q <= '0;
      outer_q <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (chr) begin
            if (full) begin
              err_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
              err_q   <= 1'b0;
            end
          end else if (tok) begin
            if (keys_ok) begin
              // Decrypt walks rows inside columns; encrypt is the transpose.
              lim_q   <= (mode_i == MODE_ENCRYPT) ? CW'(key_N) : CW'(key_M);
              olim_q  <= (mode_i == MODE_ENCRYPT) ? CW'(key_M) : CW'(key_N);
              inner_q <= '0;
              outer_q <= '0;
              acc_q   <= '0;
            end else begin
              err_q   <= 1'b1;
              count_q <= '0;
            end
          end
        end
        EMIT: begin
          if (inner_wrap) begin
            inner_q <= '0;
            acc_q   <= '0;
            outer_q <= outer_q + CW'(1);
          end else begin
            inner_q <= inner_q + CW'(1);
            acc_q   <= acc_q + olim_q;
          end
        end
        DONE: count_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_codec.sv
// Directed bench for scytale_codec: decrypt/encrypt vectors, padding,
// key errors, overflow, and reset in the middle of an emission.
module tb_scytale_codec;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       mode_i;
  logic [7:0] key_N, key_M;
  logic [7:0] data_o;
  logic       valid_o, busy, done_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];

  scytale_codec dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .mode_i  (mode_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input byte unsigned c);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = c;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_tok(input logic md, input logic [7:0] n, input logic [7:0] m);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 8'hFA;
    mode_i  = md;
    key_N   = n;
    key_M   = m;
  endtask

  task automatic set_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Called right after send_tok. Keys/mode are scrambled and junk characters
  // are driven during EMIT and DONE; none of it may affect the result.
  task automatic check_emit(input string tag);
    got_q.delete();
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = "Q";
    key_N   = 8'd7;
    key_M   = 8'd9;
    mode_i  = ~mode_i;
    foreach (exp_q[j]) begin
      chk({tag, "/busy"},  busy,    1);
      chk({tag, "/valid"}, valid_o, 1);
      chk($sformatf("%s/data%0d", tag, j), data_o, exp_q[j]);
      got_q.push_back(data_o);
      @(negedge clk);
    end
    chk({tag, "/done"},     done_o,  1);
    chk({tag, "/valid_dn"}, valid_o, 0);
    chk({tag, "/busy_dn"},  busy,    0);
    chk({tag, "/data_dn"},  data_o,  0);
    @(negedge clk);
    valid_i = 1'b0;
    chk({tag, "/done_lo"}, done_o, 0);
  endtask

  initial begin
    rst     = 1'b1;
    data_i  = '0;
    valid_i = 1'b0;
    mode_i  = 1'b0;
    key_N   = '0;
    key_M   = '0;
    #12;
    chk("rst/valid", valid_o, 0);
    chk("rst/busy",  busy,    0);
    chk("rst/done",  done_o,  0);
    chk("rst/err",   err_o,   0);
    chk("rst/data",  data_o,  0);
    @(negedge clk);
    rst = 1'b0;

    // 1: decrypt N=2 M=3
    send_str("ADBECF");
    send_tok(1'b0, 8'd2, 8'd3);
    set_exp("ABCDEF");
    check_emit("t1");

    // 2: encrypt, then feed the ciphertext back through decrypt
    send_str("ABCDEF");
    send_tok(1'b1, 8'd2, 8'd3);
    set_exp("ADBECF");
    check_emit("t2enc");
    begin
      byte unsigned ct[$];
      ct = got_q;
      foreach (ct[i]) send_char(ct[i]);
    end
    send_tok(1'b0, 8'd2, 8'd3);
    set_exp("ABCDEF");
    check_emit("t2dec");

    // 3: short message, padding where address >= 4
    send_str("ABCD");
    send_tok(1'b0, 8'd3, 8'd2);
    set_exp("ADB C ");
    check_emit("t3");

    // 4: invalid keys
    send_str("XY");
    send_tok(1'b0, 8'd0, 8'd3);
    @(negedge clk);
    valid_i = 1'b0;
    chk("t4a/err",   err_o,   1);
    chk("t4a/valid", valid_o, 0);
    chk("t4a/busy",  busy,    0);
    repeat (2) @(negedge clk);
    chk("t4a/valid_late", valid_o, 0);
    send_tok(1'b0, 8'd8, 8'd8);
    @(negedge clk);
    valid_i = 1'b0;
    chk("t4b/err",   err_o,   1);
    chk("t4b/valid", valid_o, 0);
    repeat (2) @(negedge clk);
    chk("t4b/valid_late", valid_o, 0);
    send_str("ADBECF");
    @(negedge clk);
    valid_i = 1'b0;
    chk("t4c/err_clr", err_o, 0);
    send_tok(1'b0, 8'd2, 8'd3);
    set_exp("ABCDEF");
    check_emit("t4c");

    // 5: overflow, then a full 5x10 decrypt of the first 50 characters
    for (int i = 0; i < 50; i++) send_char(8'h30 + 8'(i));
    @(negedge clk);
    chk("t5/err50", err_o, 0);
    valid_i = 1'b1;
    data_i  = 8'h7E;
    @(negedge clk);
    valid_i = 1'b0;
    chk("t5/err51", err_o, 1);
    send_tok(1'b0, 8'd5, 8'd10);
    exp_q.delete();
    for (int j = 0; j < 50; j++) exp_q.push_back(8'h30 + 8'((j % 10) * 5 + j / 10));
    check_emit("t5");

    // 6: reset during the third EMIT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_str("ADBECF");
    send_tok(1'b0, 8'd2, 8'd3);
    @(negedge clk);
    valid_i = 1'b0;
    chk("t6/busy0", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t6/data2", data_o, "C");
    #2 rst = 1'b1;
    #1;
    chk("t6/valid_rst", valid_o, 0);
    chk("t6/busy_rst",  busy,    0);
    chk("t6/data_rst",  data_o,  0);
    chk("t6/err_rst",   err_o,   0);
    @(negedge clk);
    rst = 1'b0;
    send_str("ADBECF");
    send_tok(1'b0, 8'd2, 8'd3);
    set_exp("ABCDEF");
    check_emit("t6r1");
    send_str("ABCD");
    send_tok(1'b0, 8'd3, 8'd2);
    set_exp("ADB C ");
    check_emit("t6r3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
